// File: rtl/idct2_1d_seq.sv
// idct2_1d_seq: time-multiplexed 1-D inverse DCT-II for sizes 4/8/16/32, one coefficient row per cycle.
// Define IDCT_CLIP_EN to saturate results to 16 bits; otherwise results wrap to their low 16 bits.
module idct2_1d_seq #(
    parameter int SHIFT = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   N,
    input  logic [511:0] X,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] Y,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic signed [29:0] RND = 30'sd1 <<< (SHIFT - 1);
    localparam logic [6:0] CROM [33] = '{
        7'd64, 7'd90, 7'd90, 7'd90, 7'd89, 7'd88, 7'd87, 7'd85, 7'd83, 7'd82, 7'd80,
        7'd78, 7'd75, 7'd73, 7'd70, 7'd67, 7'd64, 7'd61, 7'd57, 7'd54, 7'd50, 7'd46,
        7'd43, 7'd38, 7'd36, 7'd31, 7'd25, 7'd22, 7'd18, 7'd13, 7'd9, 7'd4, 7'd0
    };
    logic [1:0]          state;
    logic [1:0]          nr;
    logic [4:0]          k;
    logic [511:0]        xr;
    logic [511:0]        yv;
    logic [5:0]          nsz;
    logic [4:0]          last;
    logic signed [15:0]  xk;
    logic signed [29:0]  acc  [32];
    logic signed [29:0]  nsum [32];
    assign nsz       = 6'd4 << nr;
    assign last      = 5'(nsz - 6'd1);
    assign xk        = xr[16*k +: 16];
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    for (genvar n = 0; n < 32; n++) begin : g_col
        logic [6:0]         t;
        logic [6:0]         m;
        logic [5:0]         idx;
        logic signed [7:0]  coef;
        logic signed [23:0] prod;
        logic signed [29:0] r;
        logic [15:0]        v;
        // angle index only matters mod 128, so the 32/Nsize scale is a shift of the low 7 bits
        assign t    = 7'(11'(2 * n + 1) * {6'd0, k});
        assign m    = 7'(t << (2'd3 - nr));
        assign idx  = m <= 7'd32 ? m[5:0] : m <= 7'd64 ? 6'(7'd64 - m) :
                      m <= 7'd96 ? 6'(m - 7'd64) : 6'(7'd0 - m);
        assign coef = (m > 7'd32 && m <= 7'd96) ? -$signed({1'b0, CROM[idx]}) : $signed({1'b0, CROM[idx]});
        assign prod = xk * coef;
        assign nsum[n] = acc[n] + (6'(n) < nsz ? 30'(prod) : 30'sd0);
        assign r    = nsum[n] + RND;
`ifdef IDCT_CLIP_EN
        logic signed [29:0] sh;
        assign sh = r >>> SHIFT;
        assign v  = sh > 30'sd32767 ? 16'h7fff : sh < -30'sd32768 ? 16'h8000 : sh[15:0];
`else
        assign v = 16'(r >>> SHIFT);
`endif
        assign yv[16*n +: 16] = 6'(n) < nsz ? v : 16'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            nr    <= '0;
            k     <= '0;
            xr    <= '0;
            Y     <= '0;
            for (int i = 0; i < 32; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xr    <= X;
                    nr    <= N;
                    k     <= '0;
                    state <= ACCUM;
                    for (int i = 0; i < 32; i++) acc[i] <= '0;
                end
                ACCUM: begin
                    for (int i = 0; i < 32; i++) acc[i] <= nsum[i];
                    k <= k + 5'd1;
                    if (k == last) begin
                        Y     <= yv;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_idct2_1d_seq.sv
// tb_idct2_1d_seq: directed checks of idct2_1d_seq with hand-computed expected residuals.
module tb_idct2_1d_seq;
    logic         clk = 0;
    logic         rst_n = 0;
    logic [1:0]   N = '0;
    logic [511:0] X = '0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [511:0] Y;
    logic         out_valid;
    logic         out_ready = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc;
    logic [511:0] held;
    logic signed [15:0] exp8 [8];

    idct2_1d_seq dut (
        .clk(clk), .rst_n(rst_n), .N(N), .X(X), .in_valid(in_valid), .in_ready(in_ready),
        .Y(Y), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic signed [15:0] ye(input int n);
        return Y[16*n +: 16];
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic chk16(input string tag, input logic signed [15:0] obs, input logic signed [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic accept(input logic [1:0] nn, input logic [511:0] xx);
        @(negedge clk);
        N = nn;
        X = xx;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_done(input bit scramble, output int c);
        c = 0;
        while (!out_valid && c < 40) begin
            @(posedge clk);
            c++;
            #1;
            if (scramble) begin
                N = 2'b11;
                for (int i = 0; i < 16; i++) X[32*i +: 32] = $urandom;
            end
        end
        @(negedge clk);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("release_in_ready", 512'(in_ready), 512'(1));
        chk("release_out_valid", 512'(out_valid), 512'(0));
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_y", Y, '0);
        @(negedge clk);
        rst_n = 1;

        // DC, size 4
        accept(2'b00, 512'(64));
        wait_done(0, cyc);
        chk("dc4_latency", 512'(cyc), 512'(4));
        for (int i = 0; i < 4; i++) chk16($sformatf("dc4_y%0d", i), ye(i), 16'sd32);
        chk("dc4_upper_zero", {64'd0, Y[511:64]}, '0);
        release_out();

        // first AC, size 32
        accept(2'b11, 512'(128) << 16);
        wait_done(0, cyc);
        chk("ac32_latency", 512'(cyc), 512'(32));
        chk16("ac32_y0", ye(0), 16'sd90);
        chk16("ac32_y31", ye(31), -16'sd90);
        chk16("ac32_y15", ye(15), 16'sd4);
        chk16("ac32_y16", ye(16), -16'sd4);
        release_out();

        // overflow, size 4
        accept(2'b00, {464'd0, 16'd32767, 16'd32767, 16'd32767});
        wait_done(0, cyc);
`ifdef IDCT_CLIP_EN
        chk16("ovf_y0", ye(0), 16'sd32767);
`else
        chk16("ovf_y0", ye(0), -16'sd11522);
`endif
        chk16("ovf_y3", ye(3), 16'sd11520);
        release_out();

        // backpressure, size 8 first AC
        accept(2'b01, 512'(128) << 16);
        wait_done(0, cyc);
        chk("bp_latency", 512'(cyc), 512'(8));
        chk16("bp_y0", ye(0), 16'sd89);
        chk16("bp_y4", ye(4), -16'sd18);
        chk16("bp_y7", ye(7), -16'sd89);
        held = Y;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_y%0d", i), Y, held);
            chk($sformatf("bp_hold_ov%0d", i), 512'(out_valid), 512'(1));
            chk($sformatf("bp_hold_ir%0d", i), 512'(in_ready), 512'(0));
        end
        release_out();

        // input isolation: size 8, X[0]=X[2]=64, X[9] beyond size ignored
        exp8 = '{16'sd74, 16'sd50, 16'sd14, -16'sd9, -16'sd9, 16'sd14, 16'sd50, 16'sd74};
        accept(2'b01, (512'(1000) << 144) | (512'(64) << 32) | 512'(64));
        wait_done(1, cyc);
        chk("iso_latency", 512'(cyc), 512'(8));
        for (int i = 0; i < 8; i++) chk16($sformatf("iso_y%0d", i), ye(i), exp8[i]);
        chk("iso_upper_zero", {128'd0, Y[511:128]}, '0);
        release_out();

        // reset in the middle of a size-32 transform
        accept(2'b11, 512'(128) << 16);
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("mrst_out_valid", 512'(out_valid), 512'(0));
        chk("mrst_in_ready", 512'(in_ready), 512'(1));
        chk("mrst_y", Y, '0);
        @(negedge clk);
        rst_n = 1;
        accept(2'b00, 512'(64));
        wait_done(0, cyc);
        chk("post_rst_latency", 512'(cyc), 512'(4));
        for (int i = 0; i < 4; i++) chk16($sformatf("post_rst_y%0d", i), ye(i), 16'sd32);
        chk("post_rst_upper_zero", {64'd0, Y[511:64]}, '0);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
